// File: rtl/pdm_pcm_converter_pkg.sv
// Shared types and constants for the PDM microphone front end.
package pdm_pcm_converter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STARTUP,
    SETTLE,
    RUN,
    STOP
  } pdm_mic_state_e;

  localparam int unsigned PDM_MIN_HALF_PERIOD = 4;

endpackage

// File: rtl/pdm_mic_controller_clk_divider.sv
// PDM clock generator: latched half-period, pdm_clk and end-of-phase strobes.
module pdm_clk_divider
  import pdm_pcm_converter_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 run,
  input  logic                 park,
  output logic                 pdm_clk,
  output logic                 last_high_c,
  output logic                 last_low_c
);

  localparam logic [DIV_WIDTH-1:0] MIN_HALF = DIV_WIDTH'(PDM_MIN_HALF_PERIOD);

  logic [DIV_WIDTH-1:0] half_m1;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] half_c;
  logic                 phase_end_c;

  assign half_c      = (div < MIN_HALF) ? MIN_HALF : div;
  assign phase_end_c = (cnt == half_m1);
  assign last_high_c = run && phase_end_c && pdm_clk;
  assign last_low_c  = run && phase_end_c && !pdm_clk;

  // Terminal count is stored directly so the compare needs no subtractor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_m1 <= '0;
    end else if (load) begin
      half_m1 <= half_c - DIV_WIDTH'(1);
    end
  end

  // While parked the low phase is never followed by a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      pdm_clk <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      pdm_clk <= 1'b0;
    end else if (phase_end_c) begin
      cnt     <= '0;
      pdm_clk <= ~pdm_clk & ~park;
    end else begin
      cnt     <= cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pdm_mic_controller.sv
// Stereo PDM mic sequencer: clocking, L/R capture, decimator handshake and power-up FSM.
module pdm_mic_controller
  import pdm_pcm_converter_pkg::*;
#(
  parameter int unsigned DIV_WIDTH      = 8,
  parameter int unsigned STARTUP_CLKS   = 1024,
  parameter int unsigned SETTLE_SAMPLES = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [DIV_WIDTH-1:0] clk_div_i,
  output logic                 pdm_clk_o,
  input  logic                 pdm_dat_i,
  output logic                 pdm_l_data_o,
  output logic                 pdm_l_valid_o,
  input  logic                 pdm_l_ready_i,
  output logic                 pdm_r_data_o,
  output logic                 pdm_r_valid_o,
  input  logic                 pdm_r_ready_i,
  output logic                 dec_enable_o,
  input  logic                 pcm_l_valid_i,
  input  logic                 pcm_l_ready_i,
  output logic                 pcm_mute_o,
  output logic                 busy_o,
  output logic                 drop_o
);

  localparam int unsigned STARTUP_W = $clog2(STARTUP_CLKS + 1);
  localparam int unsigned SETTLE_W  = $clog2(SETTLE_SAMPLES + 1);

  pdm_mic_state_e       state_q, state_d;
  logic [STARTUP_W-1:0] startup_cnt_q, startup_cnt_d;
  logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic                 dec_enable_d, mute_d, busy_d;
  logic                 start_c, run_c, park_c, capture_en_c, l_cap_c, r_cap_c;
  logic                 last_high_c, last_low_c;
  logic                 dat_meta, dat_s;

  assign run_c        = (state_q != IDLE);
  assign park_c       = (state_q == STOP);
  assign capture_en_c = (state_q == SETTLE) || (state_q == RUN);
  assign l_cap_c      = capture_en_c && last_high_c;
  assign r_cap_c      = capture_en_c && last_low_c;

  pdm_clk_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_div (
    .clk        (clock_i),
    .rst        (reset_i),
    .load       (start_c),
    .div        (clk_div_i),
    .run        (run_c),
    .park       (park_c),
    .pdm_clk    (pdm_clk_o),
    .last_high_c(last_high_c),
    .last_low_c (last_low_c)
  );

  // Mic data is asynchronous to clock_i.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      dat_meta <= 1'b0;
      dat_s    <= 1'b0;
    end else begin
      dat_meta <= pdm_dat_i;
      dat_s    <= dat_meta;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      startup_cnt_q <= '0;
      settle_cnt_q  <= '0;
      dec_enable_o  <= 1'b0;
      pcm_mute_o    <= 1'b1;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      startup_cnt_q <= startup_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      dec_enable_o  <= dec_enable_d;
      pcm_mute_o    <= mute_d;
      busy_o        <= busy_d;
    end
  end

  // Startup counts pdm rising edges (end of each low phase); settle counts left PCM handshakes.
  always_comb begin
    state_d       = state_q;
    startup_cnt_d = startup_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    start_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d       = STARTUP;
          startup_cnt_d = '0;
          settle_cnt_d  = '0;
          start_c       = 1'b1;
        end
      end
      STARTUP: begin
        if (!enable_i) begin
          state_d = STOP;
        end else if (last_low_c) begin
          if (startup_cnt_q == STARTUP_W'(STARTUP_CLKS - 1)) state_d = SETTLE;
          else startup_cnt_d = startup_cnt_q + STARTUP_W'(1);
        end
      end
      SETTLE: begin
        if (!enable_i) begin
          state_d = STOP;
        end else if (pcm_l_valid_i && pcm_l_ready_i) begin
          if (settle_cnt_q == SETTLE_W'(SETTLE_SAMPLES - 1)) state_d = RUN;
          else settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end
      end
      RUN: begin
        if (!enable_i) state_d = STOP;
      end
      STOP: begin
        if (!pdm_l_valid_o && !pdm_r_valid_o && !pdm_clk_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    dec_enable_d = (state_d == SETTLE) || (state_d == RUN);
    mute_d       = (state_d != RUN);
    busy_d       = (state_d != IDLE);
  end

  // A capture always wins over acceptance; overwriting an unaccepted bit is a drop.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pdm_l_data_o  <= 1'b0;
      pdm_l_valid_o <= 1'b0;
      pdm_r_data_o  <= 1'b0;
      pdm_r_valid_o <= 1'b0;
      drop_o        <= 1'b0;
    end else begin
      if (l_cap_c) begin
        pdm_l_data_o  <= dat_s;
        pdm_l_valid_o <= 1'b1;
      end else if (pdm_l_ready_i) begin
        pdm_l_valid_o <= 1'b0;
      end
      if (r_cap_c) begin
        pdm_r_data_o  <= dat_s;
        pdm_r_valid_o <= 1'b1;
      end else if (pdm_r_ready_i) begin
        pdm_r_valid_o <= 1'b0;
      end
      if (start_c) begin
        drop_o <= 1'b0;
      end else if ((l_cap_c && pdm_l_valid_o && !pdm_l_ready_i) ||
                   (r_cap_c && pdm_r_valid_o && !pdm_r_ready_i)) begin
        drop_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pdm_mic_controller.sv
// Directed self-checking bench for pdm_mic_controller (short startup for sim time).
module tb_pdm_mic_controller;

  localparam int unsigned DIV_WIDTH      = 8;
  localparam int unsigned STARTUP_CLKS   = 8;
  localparam int unsigned SETTLE_SAMPLES = 16;

  logic                 clock_i = 1'b0;
  logic                 reset_i = 1'b1;
  logic                 enable_i = 1'b0;
  logic [DIV_WIDTH-1:0] clk_div_i = '0;
  logic                 pdm_dat_i = 1'b0;
  logic                 pdm_l_ready_i = 1'b1;
  logic                 pdm_r_ready_i = 1'b1;
  logic                 pcm_l_valid_i = 1'b0;
  logic                 pcm_l_ready_i = 1'b0;
  logic                 pdm_clk_o, pdm_l_data_o, pdm_l_valid_o, pdm_r_data_o, pdm_r_valid_o;
  logic                 dec_enable_o, pcm_mute_o, busy_o, drop_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [8:0] RESET_OUTS = 9'b000000100;

  pdm_mic_controller #(
    .DIV_WIDTH     (DIV_WIDTH),
    .STARTUP_CLKS  (STARTUP_CLKS),
    .SETTLE_SAMPLES(SETTLE_SAMPLES)
  ) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .clk_div_i    (clk_div_i),
    .pdm_clk_o    (pdm_clk_o),
    .pdm_dat_i    (pdm_dat_i),
    .pdm_l_data_o (pdm_l_data_o),
    .pdm_l_valid_o(pdm_l_valid_o),
    .pdm_l_ready_i(pdm_l_ready_i),
    .pdm_r_data_o (pdm_r_data_o),
    .pdm_r_valid_o(pdm_r_valid_o),
    .pdm_r_ready_i(pdm_r_ready_i),
    .dec_enable_o (dec_enable_o),
    .pcm_l_valid_i(pcm_l_valid_i),
    .pcm_l_ready_i(pcm_l_ready_i),
    .pcm_mute_o   (pcm_mute_o),
    .busy_o       (busy_o),
    .drop_o       (drop_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock_i);
      cyc++;
    end
  endtask

  function automatic logic [8:0] outs();
    return {pdm_clk_o, pdm_l_valid_o, pdm_l_data_o, pdm_r_valid_o, pdm_r_data_o,
            dec_enable_o, pcm_mute_o, busy_o, drop_o};
  endfunction

  task automatic test_reset();
    reset_i = 1'b1;
    step(2);
    checks++; if (outs() !== RESET_OUTS) begin errors++; $display("FAIL reset_outs got %b want %b", outs(), RESET_OUTS); end
    reset_i = 1'b0;
    step(3);
    checks++; if (outs() !== RESET_OUTS) begin errors++; $display("FAIL idle_hold got %b want %b", outs(), RESET_OUTS); end
  endtask

  task automatic test_startup();
    int  rises = 0, last = 0, bad_period = 0, early_valid = 0, start;
    bit  done = 0;
    logic prev;
    clk_div_i = 8'd2;
    enable_i  = 1'b1;
    step(1);
    checks++; if ({busy_o, pdm_clk_o} !== 2'b10) begin errors++; $display("FAIL start_busy got %b want 10", {busy_o, pdm_clk_o}); end
    start = cyc;
    prev  = pdm_clk_o;
    for (int i = 0; i < 400 && !done; i++) begin
      step(1);
      if (pdm_l_valid_o || pdm_r_valid_o) early_valid++;
      if (pdm_clk_o && !prev) begin
        rises++;
        if (rises == 1) begin
          if (cyc - start != 4) bad_period++;
        end else if (cyc - last != 8) bad_period++;
        last = cyc;
      end
      prev = pdm_clk_o;
      if (dec_enable_o) done = 1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL startup_timeout got %0d want 1", done); end
    checks++; if (rises != 8) begin errors++; $display("FAIL startup_rises got %0d want 8", rises); end
    checks++; if (bad_period != 0) begin errors++; $display("FAIL clamp_period got %0d bad want 0", bad_period); end
    checks++; if (early_valid != 0) begin errors++; $display("FAIL startup_capture got %0d want 0", early_valid); end
    checks++; if ({pdm_clk_o, pcm_mute_o} !== 2'b11) begin errors++; $display("FAIL settle_entry got %b want 11", {pdm_clk_o, pcm_mute_o}); end
  endtask

  task automatic test_stream();
    int lv = 0, rv = 0, lbad = 0, rbad = 0, rises = 0;
    logic prev;
    prev = pdm_clk_o;
    clk_div_i = 8'd6;
    for (int i = 0; i < 80; i++) begin
      pdm_dat_i = pdm_clk_o;
      step(1);
      if (pdm_clk_o && !prev) rises++;
      if (pdm_l_valid_o) begin
        lv++;
        if (pdm_l_data_o !== 1'b1 || !(prev && !pdm_clk_o)) lbad++;
      end
      if (pdm_r_valid_o) begin
        rv++;
        if (pdm_r_data_o !== 1'b0 || !(!prev && pdm_clk_o)) rbad++;
      end
      prev = pdm_clk_o;
    end
    checks++; if (lv != 10) begin errors++; $display("FAIL left_pulses got %0d want 10", lv); end
    checks++; if (rv != 10) begin errors++; $display("FAIL right_pulses got %0d want 10", rv); end
    checks++; if (lbad != 0) begin errors++; $display("FAIL left_data_align got %0d bad want 0", lbad); end
    checks++; if (rbad != 0) begin errors++; $display("FAIL right_data_align got %0d bad want 0", rbad); end
    checks++; if (rises != 10) begin errors++; $display("FAIL div_change_ignored got %0d rises want 10", rises); end
    checks++; if ({drop_o, pcm_mute_o} !== 2'b01) begin errors++; $display("FAIL stream_drop_mute got %b want 01", {drop_o, pcm_mute_o}); end
  endtask

  task automatic test_settle();
    pcm_l_valid_i = 1'b1; pcm_l_ready_i = 1'b0;
    step(1);
    pcm_l_valid_i = 1'b0; pcm_l_ready_i = 1'b1;
    step(1);
    for (int i = 1; i <= 16; i++) begin
      pcm_l_valid_i = 1'b1; pcm_l_ready_i = 1'b1;
      step(1);
      pcm_l_valid_i = 1'b0; pcm_l_ready_i = 1'b0;
      checks++;
      if (pcm_mute_o !== ((i < 16) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL settle_mute_%0d got %b want %b", i, pcm_mute_o, (i < 16));
      end
      step(1);
    end
    checks++; if ({dec_enable_o, busy_o, pcm_mute_o} !== 3'b110) begin errors++; $display("FAIL run_state got %b want 110", {dec_enable_o, busy_o, pcm_mute_o}); end
  endtask

  task automatic test_drop();
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1);
      if (pdm_l_valid_o) got = 1;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL drop_sync_timeout got %0d want 1", got); end
    step(1);
    pdm_l_ready_i = 1'b0; pdm_dat_i = 1'b0;
    step(7);
    checks++; if ({pdm_l_valid_o, pdm_l_data_o, drop_o} !== 3'b100) begin errors++; $display("FAIL drop_first got %b want 100", {pdm_l_valid_o, pdm_l_data_o, drop_o}); end
    pdm_dat_i = 1'b1;
    step(4);
    checks++; if ({pdm_l_valid_o, pdm_l_data_o} !== 2'b10) begin errors++; $display("FAIL drop_hold got %b want 10", {pdm_l_valid_o, pdm_l_data_o}); end
    step(4);
    checks++; if ({pdm_l_valid_o, pdm_l_data_o, drop_o} !== 3'b111) begin errors++; $display("FAIL drop_second got %b want 111", {pdm_l_valid_o, pdm_l_data_o, drop_o}); end
    pdm_l_ready_i = 1'b1;
    step(1);
    checks++; if ({pdm_l_valid_o, drop_o} !== 2'b01) begin errors++; $display("FAIL drop_accept got %b want 01", {pdm_l_valid_o, drop_o}); end
  endtask

  task automatic test_stop();
    bit got = 0;
    int s6, r1 = 0, r2 = 0;
    logic prev;
    prev = pdm_clk_o;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1);
      if (pdm_clk_o && !prev) got = 1;
      prev = pdm_clk_o;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL stop_sync_timeout got %0d want 1", got); end
    step(1);
    enable_i = 1'b0;
    step(1);
    checks++; if ({dec_enable_o, pcm_mute_o, busy_o, pdm_clk_o} !== 4'b0111) begin errors++; $display("FAIL stop_entry got %b want 0111", {dec_enable_o, pcm_mute_o, busy_o, pdm_clk_o}); end
    step(1);
    enable_i = 1'b1;
    checks++; if (pdm_clk_o !== 1'b1) begin errors++; $display("FAIL stop_high_finish got %b want 1", pdm_clk_o); end
    step(1);
    checks++; if ({pdm_clk_o, pdm_l_valid_o, busy_o} !== 3'b001) begin errors++; $display("FAIL stop_low got %b want 001", {pdm_clk_o, pdm_l_valid_o, busy_o}); end
    step(1);
    checks++; if ({busy_o, pdm_clk_o, drop_o} !== 3'b001) begin errors++; $display("FAIL stop_idle got %b want 001", {busy_o, pdm_clk_o, drop_o}); end
    step(1);
    checks++; if ({busy_o, pdm_clk_o, drop_o, dec_enable_o, pcm_mute_o} !== 5'b10001) begin errors++; $display("FAIL restart got %b want 10001", {busy_o, pdm_clk_o, drop_o, dec_enable_o, pcm_mute_o}); end
    s6   = cyc;
    prev = pdm_clk_o;
    for (int i = 0; i < 60 && r2 == 0; i++) begin
      step(1);
      if (pdm_clk_o && !prev) begin
        if (r1 == 0) r1 = cyc; else r2 = cyc;
      end
      prev = pdm_clk_o;
    end
    checks++; if (r1 - s6 != 6) begin errors++; $display("FAIL relatch_first got %0d want 6", r1 - s6); end
    checks++; if (r2 - r1 != 12) begin errors++; $display("FAIL relatch_period got %0d want 12", r2 - r1); end
    enable_i = 1'b0;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      step(1);
      if (!busy_o) got = 1;
    end
    checks++; if ({got, pdm_clk_o} !== 2'b10) begin errors++; $display("FAIL stop_drain got %b want 10", {got, pdm_clk_o}); end
  endtask

  task automatic test_reset_midrun();
    bit got = 0;
    clk_div_i = 8'd4;
    enable_i  = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      step(1);
      if (dec_enable_o) got = 1;
    end
    pcm_l_valid_i = 1'b1; pcm_l_ready_i = 1'b1;
    step(16);
    pcm_l_valid_i = 1'b0; pcm_l_ready_i = 1'b0;
    checks++; if ({got, pcm_mute_o} !== 2'b10) begin errors++; $display("FAIL midrun_reach got %b want 10", {got, pcm_mute_o}); end
    pdm_l_ready_i = 1'b0; pdm_dat_i = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1);
      if (pdm_l_valid_o) got = 1;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL midrun_valid got %0d want 1", got); end
    #2 reset_i = 1'b1;
    #1;
    checks++; if (outs() !== RESET_OUTS) begin errors++; $display("FAIL async_reset got %b want %b", outs(), RESET_OUTS); end
    enable_i = 1'b0;
    step(1);
    reset_i = 1'b0; pdm_l_ready_i = 1'b1;
    step(4);
    checks++; if (outs() !== RESET_OUTS) begin errors++; $display("FAIL post_reset_idle got %b want %b", outs(), RESET_OUTS); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stream();
    test_settle();
    test_drop();
    test_stop();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
